// File: rtl/alu_op_controller.sv
// Front-panel controller: three push-buttons select an opcode and launch one ALU operation
// with start/done handshake and watchdog. Optional debounce filter: ALU_OPCTL_DEBOUNCE_EN.
module alu_op_controller #(
    parameter int NUM_OPS         = 16,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_exec,
    input  logic       alu_done,
    output logic [3:0] op_sel,
    output logic [3:0] alu_op,
    output logic       alu_start,
    output logic       busy,
    output logic       op_ok,
    output logic       op_timeout
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]      SEL_MAX  = 4'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    // Button vectors are ordered {exec, prev, next}.
    logic [2:0] raw_s;
    logic [2:0] sync1_r;
    logic [2:0] sync2_r;
    logic [2:0] deb_s;
    logic [2:0] deb_prev_r;
    logic [2:0] evt_s;

    state_t           state_r, state_nx;
    logic [3:0]       op_sel_r, op_sel_nx;
    logic [3:0]       alu_op_r, alu_op_nx;
    logic             op_ok_r, op_ok_nx;
    logic             op_timeout_r, op_timeout_nx;
    logic             alu_start_r;
    logic             busy_r;
    logic [CNT_W-1:0] wd_cnt_r, wd_cnt_nx;

    assign raw_s = {btn_exec, btn_prev, btn_next};

    // Two-flop synchronizers and the delayed filtered level used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 3'b000;
            sync2_r    <= 3'b000;
            deb_prev_r <= 3'b000;
        end else begin
            sync1_r    <= raw_s;
            sync2_r    <= sync1_r;
            deb_prev_r <= deb_s;
        end
    end

`ifdef ALU_OPCTL_DEBOUNCE_EN
    localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_r [3];
    logic [2:0]      deb_r;

    // Debounce filter: the level follows s2 only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else if (db_cnt_r[i] == DB_LAST) begin
                    deb_r[i]    <= sync2_r[i];
                    db_cnt_r[i] <= {DB_W{1'b0}};
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    assign deb_s = deb_r;
`else
    assign deb_s = sync2_r;
`endif

    assign evt_s = deb_s & ~deb_prev_r;

    // Next-state and next-output logic for the launch/wait sequencer.
    always_comb begin
        state_nx      = state_r;
        op_sel_nx     = op_sel_r;
        alu_op_nx     = alu_op_r;
        op_ok_nx      = op_ok_r;
        op_timeout_nx = op_timeout_r;
        wd_cnt_nx     = wd_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (evt_s[2]) begin
                    alu_op_nx     = op_sel_r;
                    op_ok_nx      = 1'b0;
                    op_timeout_nx = 1'b0;
                    state_nx      = ST_LAUNCH;
                end else if (evt_s[0] && !evt_s[1]) begin
                    op_sel_nx = (op_sel_r == SEL_MAX) ? 4'd0 : op_sel_r + 4'd1;
                end else if (evt_s[1] && !evt_s[0]) begin
                    op_sel_nx = (op_sel_r == 4'd0) ? SEL_MAX : op_sel_r - 4'd1;
                end else begin
                    op_sel_nx = op_sel_r;
                end
            end
            ST_LAUNCH: begin
                wd_cnt_nx = {CNT_W{1'b0}};
                state_nx  = ST_WAIT;
            end
            ST_WAIT: begin
                // Done takes priority over an expiry in the same cycle.
                if (alu_done) begin
                    op_ok_nx = 1'b1;
                    state_nx = ST_IDLE;
                end else if (wd_cnt_r == CNT_LAST) begin
                    op_timeout_nx = 1'b1;
                    state_nx      = ST_IDLE;
                end else begin
                    wd_cnt_nx = wd_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; start and busy are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            op_sel_r     <= 4'd0;
            alu_op_r     <= 4'd0;
            op_ok_r      <= 1'b0;
            op_timeout_r <= 1'b0;
            alu_start_r  <= 1'b0;
            busy_r       <= 1'b0;
            wd_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nx;
            op_sel_r     <= op_sel_nx;
            alu_op_r     <= alu_op_nx;
            op_ok_r      <= op_ok_nx;
            op_timeout_r <= op_timeout_nx;
            alu_start_r  <= (state_nx == ST_LAUNCH);
            busy_r       <= (state_nx != ST_IDLE);
            wd_cnt_r     <= wd_cnt_nx;
        end
    end

    assign op_sel     = op_sel_r;
    assign alu_op     = alu_op_r;
    assign alu_start  = alu_start_r;
    assign busy       = busy_r;
    assign op_ok      = op_ok_r;
    assign op_timeout = op_timeout_r;

endmodule

// File: tb/tb_alu_op_controller.sv
// Self-checking bench for alu_op_controller: directed test-plan cases plus randomized
// button/exec traffic against a transaction-level model of selection and completion.
module tb_alu_op_controller;

    localparam int NOPS = 16;
    localparam int DEB  = 16;
    localparam int TMO  = 64;
`ifdef ALU_OPCTL_DEBOUNCE_EN
    localparam int DEFF = DEB;
`else
    localparam int DEFF = 0;
`endif
    localparam int LAT    = 3 + DEFF;
    localparam int HOLD   = DEFF + 2;
    localparam int SETTLE = DEFF + 6;

    logic       clk = 1'b0;
    logic       rst, btn_next, btn_prev, btn_exec, alu_done;
    logic [3:0] op_sel, alu_op;
    logic       alu_start, busy, op_ok, op_timeout;

    int total = 0;
    int bad   = 0;
    int model_sel = 0;
    int model_op  = 0;

    always #5 clk = ~clk;

    alu_op_controller #(
        .NUM_OPS(NOPS), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
        .btn_exec(btn_exec), .alu_done(alu_done), .op_sel(op_sel), .alu_op(alu_op),
        .alu_start(alu_start), .busy(busy), .op_ok(op_ok), .op_timeout(op_timeout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input string tag, input bit n, input bit p);
        btn_next = n;
        btn_prev = p;
        repeat (HOLD) tick;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (SETTLE) tick;
        if (n && !p) model_sel = (model_sel + 1) % NOPS;
        else if (p && !n) model_sel = (model_sel + NOPS - 1) % NOPS;
        check_eq(tag, 32'(op_sel), model_sel);
    endtask

    // d: cycles after alu_start at which alu_done pulses (-1 = never).
    task automatic run_exec(input bit with_next, input int d, input bit lock_req);
        int  launch_at, starts, busy_n, exp_busy;
        bit  ended, exp_ok, lock;
        launch_at = -1;
        starts    = 0;
        busy_n    = 0;
        ended     = 1'b0;
        model_op  = model_sel;
        exp_ok    = (d >= 1 && d <= TMO);
        exp_busy  = exp_ok ? d + 1 : TMO + 1;
        lock      = lock_req && (exp_busy > LAT + 3);
        btn_exec  = 1'b1;
        btn_next  = with_next;
        for (int cyc = 1; cyc <= LAT + TMO + HOLD + 20 && !ended; cyc++) begin
            tick;
            if (alu_start === 1'b1) begin
                starts++;
                if (launch_at < 0) begin
                    launch_at = cyc;
                    check_eq("launch_lat", cyc, LAT);
                    check_eq("status_clr", 32'({op_ok, op_timeout}), 0);
                    check_eq("alu_op_launch", 32'(alu_op), model_op);
                end
            end
            if (busy === 1'b1) busy_n++;
            else if (launch_at >= 0) ended = 1'b1;
            if (cyc == HOLD) begin
                btn_exec = 1'b0;
                btn_next = 1'b0;
            end
            if (launch_at >= 0) begin
                alu_done = (d >= 0 && cyc - launch_at == d);
                if (lock && cyc - launch_at == 1) btn_next = 1'b1;
                if (lock && cyc - launch_at == 1 + HOLD) btn_next = 1'b0;
            end
        end
        alu_done = 1'b0;
        btn_exec = 1'b0;
        btn_next = 1'b0;
        check_eq("exec_end", 32'(ended), 1);
        check_eq("start_pulses", starts, 1);
        check_eq("busy_cycles", busy_n, exp_busy);
        check_eq("op_ok", 32'(op_ok), 32'(exp_ok));
        check_eq("op_timeout", 32'(op_timeout), 32'(!exp_ok));
        check_eq("alu_op_after", 32'(alu_op), model_op);
        repeat (SETTLE) tick;
        check_eq("op_sel_after_exec", 32'(op_sel), model_sel);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r, d;
        rst      = 1'b1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        btn_exec = 1'b0;
        alu_done = 1'b0;
        repeat (3) tick;
        check_eq("rst_op_sel", 32'(op_sel), 0);
        check_eq("rst_alu_op", 32'(alu_op), 0);
        check_eq("rst_start", 32'(alu_start), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ok", 32'(op_ok), 0);
        check_eq("rst_timeout", 32'(op_timeout), 0);
        rst = 1'b0;
        tick;

        // Exact press-to-update latency on the first next press.
        btn_next = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            tick;
            if (i == HOLD) btn_next = 1'b0;
            if (i == LAT - 1) check_eq("lat_before", 32'(op_sel), 0);
        end
        btn_next = 1'b0;
        check_eq("lat_at", 32'(op_sel), 1);
        model_sel = 1;
        repeat (SETTLE) tick;

        press("next2", 1'b1, 1'b0);
        press("next3", 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) press("prev_wrap", 1'b0, 1'b1);
        check_eq("wrap_to_15", 32'(op_sel), 15);

`ifdef ALU_OPCTL_DEBOUNCE_EN
        btn_next = 1'b1;
        repeat (10) tick;
        btn_next = 1'b0;
        repeat (SETTLE) tick;
        check_eq("glitch_reject", 32'(op_sel), model_sel);
`endif

        for (int i = 0; i < 5; i++) press("to_four", 1'b1, 1'b0);
        check_eq("sel_four", 32'(op_sel), 4);

        run_exec(1'b0, 5, 1'b0);
        run_exec(1'b0, -1, 1'b0);
        run_exec(1'b0, TMO, 1'b0);
        run_exec(1'b0, 0, 1'b0);
        run_exec(1'b0, 40, 1'b1);
        press("next_prev_same", 1'b1, 1'b1);
        run_exec(1'b1, 3, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 4);
            d = $urandom_range(0, 9);
            if (d == 0) d = -1;
            else if (d == 1) d = 0;
            else d = $urandom_range(1, TMO + 2);
            case (r)
                0: press("rnd_next", 1'b1, 1'b0);
                1: press("rnd_prev", 1'b0, 1'b1);
                2: press("rnd_both", 1'b1, 1'b1);
                3: run_exec(1'b0, d, 1'($urandom_range(0, 1)));
                default: run_exec(1'b1, d, 1'b0);
            endcase
        end

        // Reset while waiting for the ALU, then a late done.
        if (model_sel == 0) press("pre_rst", 1'b1, 1'b0);
        btn_exec = 1'b1;
        for (int i = 1; i <= LAT + 3; i++) begin
            tick;
            if (i == HOLD) btn_exec = 1'b0;
        end
        check_eq("busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_sel = 0;
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_start", 32'(alu_start), 0);
        check_eq("midrst_op_sel", 32'(op_sel), 0);
        check_eq("midrst_alu_op", 32'(alu_op), 0);
        check_eq("midrst_ok", 32'(op_ok), 0);
        check_eq("midrst_timeout", 32'(op_timeout), 0);
        alu_done = 1'b1;
        tick;
        tick;
        alu_done = 1'b0;
        check_eq("late_done_ok", 32'(op_ok), 0);
        check_eq("late_done_busy", 32'(busy), 0);
        check_eq("late_done_timeout", 32'(op_timeout), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
